// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux scan controller: FSM encoding, default select width, settle counter width.
// Optional feature macro used by the top: MUX_SCAN_PARITY_EN.
package mux_scan_pkg;

    localparam int SEL_W_DEF = 2;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Insert one sampled bit into a partially assembled word at the given position.
    function automatic logic [31:0] merge_bit(input logic [31:0] cur, input int pos, input logic b);
        logic [31:0] r;
        r      = cur;
        r[pos] = b;
        return r;
    endfunction

endpackage

// File: rtl/mux_scan_timer.sv
// Loadable settle down-counter with a zero flag; load wins over decrement.
// Latency: count visible the edge after load/dec; zero is combinational from the count.
module mux_scan_timer
    import mux_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps the mux select 0..N_IN-1, samples mux_out after a settle delay, presents the word on valid/ready.
// Latency: valid at edge N_IN*(SETTLE_CYC+1) after start; HOLD stalls until ready. Macro MUX_SCAN_PARITY_EN adds word_par.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SEL_W      = SEL_W_DEF,
    parameter int SETTLE_CYC = 1
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic [SEL_W-1:0]        s,
    input  logic                    mux_out,
    output logic                    busy,
    output logic [(1<<SEL_W)-1:0]   word,
    output logic                    valid,
    input  logic                    ready
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic                    word_par
`endif
);

    localparam int               N_IN      = 1 << SEL_W;
    localparam logic [SEL_W-1:0] S_LAST    = SEL_W'(N_IN - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);

    state_t          state;
    logic [N_IN-1:0] capture;
    logic [N_IN-1:0] merged;
    logic [31:0]     merged_full;
    logic            tmr_load;
    logic            tmr_dec;
    logic            tmr_zero;

    // Capture with the bit being sampled this edge already folded in, so the
    // final bit can go straight into word without an extra cycle.
    always_comb begin
        merged_full = merge_bit(32'(capture), int'(s), mux_out);
        merged      = merged_full[N_IN-1:0];
    end

    always_comb begin
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        case (state)
            IDLE: begin
                tmr_load = start;
            end
            SETTLE: begin
                if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else if (s != S_LAST) begin
                    tmr_load = 1'b1;
                end
            end
            default: begin
                tmr_load = 1'b0;
                tmr_dec  = 1'b0;
            end
        endcase
    end

    mux_scan_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (SETTLE_LD),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            s        <= '0;
            capture  <= '0;
            word     <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            word_par <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        s     <= '0;
                        busy  <= 1'b1;
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (tmr_zero) begin
                        capture <= merged;
                        if (s == S_LAST) begin
                            word     <= merged;
                            valid    <= 1'b1;
                            state    <= HOLD;
`ifdef MUX_SCAN_PARITY_EN
                            word_par <= ^merged;
`endif
                        end else begin
                            s <= s + SEL_W'(1);
                        end
                    end
                end
                HOLD: begin
                    // The handshake edge returns to IDLE; a start seen here is not taken.
                    if (ready) begin
                        valid <= 1'b0;
                        s     <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    valid <= 1'b0;
                    s     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: two instances (settle 1 and settle 0) against a transaction-level model.
module tb_mux_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start   [2];
    logic       ready   [2];
    logic [3:0] a       [2];
    logic       mux_out [2];
    logic [1:0] s_o     [2];
    logic       busy_o  [2];
    logic       vld     [2];
    logic [3:0] word_o  [2];
`ifdef MUX_SCAN_PARITY_EN
    logic       par_o   [2];
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    // Model state: edges elapsed since the accepting edge, sampled bits, held word.
    bit       m_active [2];
    bit       m_hold   [2];
    int       m_k      [2];
    logic [3:0] m_cap  [2];
    logic [3:0] m_word [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mux_out[0] = a[0][s_o[0]];
    assign mux_out[1] = a[1][s_o[1]];

    mux_scan_ctrl #(.SEL_W(2), .SETTLE_CYC(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .s(s_o[0]), .mux_out(mux_out[0]),
        .busy(busy_o[0]), .word(word_o[0]), .valid(vld[0]), .ready(ready[0])
`ifdef MUX_SCAN_PARITY_EN
        , .word_par(par_o[0])
`endif
    );

    mux_scan_ctrl #(.SEL_W(2), .SETTLE_CYC(0)) dut_s0 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .s(s_o[1]), .mux_out(mux_out[1]),
        .busy(busy_o[1]), .word(word_o[1]), .valid(vld[1]), .ready(ready[1])
`ifdef MUX_SCAN_PARITY_EN
        , .word_par(par_o[1])
`endif
    );

    function automatic int per_bit(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_active[i] = 0;
                m_hold[i]   = 0;
                m_k[i]      = 0;
                m_word[i]   = 4'b0;
            end else if (m_hold[i]) begin
                if (ready[i]) m_hold[i] = 0;
            end else if (m_active[i]) begin
                int idx;
                idx = m_k[i] / per_bit(i);
                m_k[i]++;
                if (m_k[i] % per_bit(i) == 0) begin
                    m_cap[i][idx] = a[i][idx];
                    if (m_k[i] == 4 * per_bit(i)) begin
                        m_word[i]   = m_cap[i];
                        m_hold[i]   = 1;
                        m_active[i] = 0;
                    end
                end
            end else if (start[i]) begin
                m_active[i] = 1;
                m_k[i]      = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                int exp_s;
                exp_s = m_hold[i] ? 3 : (m_active[i] ? m_k[i] / per_bit(i) : 0);
                check($sformatf("model_s[%0d]", i), 32'(s_o[i]), 32'(exp_s));
                check($sformatf("model_valid[%0d]", i), 32'(vld[i]), 32'(m_hold[i]));
                check($sformatf("model_busy[%0d]", i), 32'(busy_o[i]), 32'(m_hold[i] | m_active[i]));
                check($sformatf("model_word[%0d]", i), 32'(word_o[i]), 32'(m_word[i]));
`ifdef MUX_SCAN_PARITY_EN
                check($sformatf("model_par[%0d]", i), 32'(par_o[i]), 32'(^m_word[i]));
`endif
            end
        end
    end

    // Counts edges after the accepting edge until valid is seen; bounded.
    task automatic wait_valid(input int i, output int n);
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (vld[i] === 1'b1) return;
        end
        check($sformatf("valid_timeout[%0d]", i), 32'(n), 32'(0));
    endtask

    task automatic pulse_start(input int i);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = '{1'b1, 1'b1};
        ready = '{1'b1, 1'b1};
        a     = '{4'b0, 4'b0};
        @(posedge clk);
        #1 chk_en = 1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_s", 32'(s_o[i]), 32'd0);
            check("rst_valid", 32'(vld[i]), 32'd0);
            check("rst_busy", 32'(busy_o[i]), 32'd0);
            check("rst_word", 32'(word_o[i]), 32'd0);
        end
        rst_n = 1'b1;
        start = '{1'b0, 1'b0};
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy_o[0]), 32'd0);
        check("idle_s", 32'(s_o[0]), 32'd0);

        a[0] = 4'b1010;
        pulse_start(0);
        check("basic_s_edge0", 32'(s_o[0]), 32'd0);
        wait_valid(0, n);
        check("basic_latency", 32'(n), 32'd8);
        check("basic_word", 32'(word_o[0]), 32'hA);
        @(negedge clk);
        check("basic_drop", 32'(vld[0]), 32'd0);

        a[0] = 4'b0110;
        ready[0] = 1'b0;
        pulse_start(0);
        wait_valid(0, n);
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", 32'(vld[0]), 32'd1);
            check("bp_word", 32'(word_o[0]), 32'h6);
            check("bp_s", 32'(s_o[0]), 32'd3);
        end
        ready[0] = 1'b1;
        @(negedge clk);
        check("bp_valid_drop", 32'(vld[0]), 32'd0);
        check("bp_busy_drop", 32'(busy_o[0]), 32'd0);

        a[1] = 4'b1101;
        start[1] = 1'b1;
        @(negedge clk);
        wait_valid(1, n);
        check("zs_latency", 32'(n), 32'd4);
        check("zs_word", 32'(word_o[1]), 32'hD);
        @(negedge clk);
        check("zs_idle_busy", 32'(busy_o[1]), 32'd0);
        @(negedge clk);
        check("zs_rescan_busy", 32'(busy_o[1]), 32'd1);
        start[1] = 1'b0;
        wait_valid(1, n);
        check("zs_latency2", 32'(n), 32'd4);
        @(negedge clk);

        a[0] = 4'b1111;
        pulse_start(0);
        repeat (4) @(negedge clk);
        check("mid_s_before_rst", 32'(s_o[0]), 32'd2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            check("mid_valid", 32'(vld[0]), 32'd0);
            check("mid_word", 32'(word_o[0]), 32'd0);
            check("mid_s", 32'(s_o[0]), 32'd0);
        end
        pulse_start(0);
        wait_valid(0, n);
        check("mid_rescan_word", 32'(word_o[0]), 32'hF);
        @(negedge clk);

`ifdef MUX_SCAN_PARITY_EN
        a[0] = 4'b0111;
        pulse_start(0);
        wait_valid(0, n);
        check("par_odd", 32'(par_o[0]), 32'd1);
        @(negedge clk);
        a[0] = 4'b0011;
        pulse_start(0);
        wait_valid(0, n);
        check("par_even", 32'(par_o[0]), 32'd0);
        @(negedge clk);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
